// File: rtl/gsim_pkg.sv
// Shared constants and state encoding for the Gauss-Seidel solver control,
// datapath and benches.
package gsim_pkg;

  localparam int N_ELEM = 16;
  localparam int IDX_W  = 4;
  localparam int ITER_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4,
    FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/gsim_ctrl.sv
// Sequencer for a Gauss-Seidel solver: loads b, runs strictly ordered x updates
// for the requested number of sweeps, then streams x out and pulses done.
module gsim_ctrl
  import gsim_pkg::*;
#(
  parameter int N_ELEM = gsim_pkg::N_ELEM,
  parameter int ITER_W = gsim_pkg::ITER_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  input  logic [ITER_W-1:0] iter_num,
  output logic              b_we,
  output logic [IDX_W-1:0]  b_waddr,
  output logic              x_clr,
  output logic              upd_start,
  output logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_done,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  upd_idx_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] sweep_q;
  logic              upd_start_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [ITER_W-1:0] iter_d;
  logic [ITER_W:0]   sweep_d;
  logic              more_sweeps;

  assign iter_d      = (iter_num == '0) ? ITER_W'(1) : iter_num;
  assign sweep_d     = {1'b0, sweep_q} + (ITER_W + 1)'(1);
  assign more_sweeps = sweep_d < {1'b0, iter_q};

  // The b write must land in the acceptance cycle, so it is decoded directly
  // from in_en; the reset term keeps it quiet while reset is held low.
  assign b_we    = reset & in_en & ((state_q == IDLE) | (state_q == LOAD));
  assign x_clr   = reset & in_en & (state_q == IDLE);
  assign b_waddr = cnt_q;

  assign upd_start = upd_start_q;
  assign upd_idx   = upd_idx_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      upd_idx_q   <= '0;
      out_idx_q   <= '0;
      iter_q      <= '0;
      sweep_q     <= '0;
      upd_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_en) begin
            cnt_q   <= IDX_W'(1);
            iter_q  <= iter_d;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (in_en) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q       <= '0;
              upd_idx_q   <= '0;
              sweep_q     <= '0;
              upd_start_q <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        ISSUE: begin
          upd_start_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // Next update is only issued once the previous x write has landed.
          if (upd_done) begin
            if (upd_idx_q != LAST_IDX) begin
              upd_idx_q   <= upd_idx_q + IDX_W'(1);
              upd_start_q <= 1'b1;
              state_q     <= ISSUE;
            end else if (more_sweeps) begin
              upd_idx_q   <= '0;
              sweep_q     <= sweep_d[ITER_W-1:0];
              upd_start_q <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              out_idx_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end
          end
        end
        OUT: begin
          if (out_idx_q == LAST_IDX) begin
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= FIN;
          end else begin
            out_idx_q <= out_idx_q + IDX_W'(1);
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
